pic_bus_sequencer: RTL and testbench
====================================

Name: pic_bus_sequencer

Overview:
- Synchronous master for the 8259 PIC register interface (WD, RD, A0, data_bus).
- On a start pulse it replays the full initialisation sequence (ICW1, ICW2, optional ICW3, optional ICW4, then OCW1 mask) from a registered configuration snapshot.
- After initialisation it serves single runtime commands: OCW writes and IRR/ISR status reads.
- Sits between the host/CPU-side logic and the PIC control logic, and owns all bus strobe timing.

Parameters:
STROBE_CYCLES, 2, clocks WD/RD held low per access (legal 1..15)
UPM_8086, 1, value written to ICW4 bit0

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high
start  in  1  one-cycle pulse; begin (re)initialisation
cfg_ltim  in  1  ICW1 level-trigger bit
cfg_sngl  in  1  ICW1 single-mode bit
cfg_ic4  in  1  ICW4 required
cfg_vector_base  in  5  ICW2[7:3]
cfg_icw3  in  8  ICW3 byte (slave mask or slave id)
cfg_aeoi  in  1  ICW4 auto-EOI
cfg_ms  in  1  ICW4 master/slave
cfg_buf  in  1  ICW4 buffered mode
cfg_mask  in  8  initial OCW1 mask
cmd_valid  in  1  runtime command request
cmd_ready  out  1  command accepted when valid&ready
cmd_read  in  1  1 = read access, 0 = write
cmd_a0  in  1  A0 for the command
cmd_data  in  8  write byte (ignored on read)
rsp_valid  out  1  one-cycle pulse, read data valid
rsp_data  out  8  sampled read byte
busy  out  1  access or init sequence in progress
init_done  out  1  initialisation complete
WD  out  1  active-low write strobe
RD  out  1  active-low read strobe
A0  out  1  register select
bus_dout  out  8  write data
bus_oe  out  1  drive enable for bus_dout
bus_din  in  8  read data from data_bus

Behaviour:
- Reset values: WD=1, RD=1, A0=0, bus_dout=0, bus_oe=0, cmd_ready=0, rsp_valid=0, rsp_data=0, busy=0, init_done=0. The FSM goes to IDLE and the step register goes to ICW1.
- Reset asserted mid-access deasserts strobes at the next edge. No partial-cycle completion.
- Byte encodings:
  - ICW1 = {3'b000, 1, ltim, 0, sngl, ic4}, A0=0
  - ICW2 = {vector_base, 3'b000}, A0=1
  - ICW3 = cfg_icw3, A0=1
  - ICW4 = {4'b0000, buf, ms, aeoi, UPM_8086}, A0=1
  - OCW1 = cfg_mask, A0=1
- start in IDLE or READY: all cfg_* are latched that cycle. init_done clears, busy sets, step=ICW1. start is ignored while busy.
- Step order: ICW1 -> ICW2 -> (ICW3 if !sngl) -> (ICW4 if ic4) -> OCW1 -> DONE. Skip decisions use the latched cfg.
- Access FSM, one byte per access:
  - SETUP, 1 clk: A0/bus_dout valid, bus_oe=1 for write, strobes high.
  - STROBE, STROBE_CYCLES clks: WD (write) or RD (read) low.
  - HOLD, 1 clk: strobes high; A0/bus_dout/bus_oe unchanged.
  - Then LOAD next step, or READY.
  - Write access = STROBE_CYCLES+2 clocks. LOAD adds 1 clock between bytes.
- WD and RD are never low simultaneously. A0/data never change while a strobe is low.
- DONE: init_done=1 and busy=0 on the cycle after the OCW1 HOLD. FSM enters READY.
- READY: cmd_ready=1 when init_done & !busy & !start. Handshake cmd_valid&cmd_ready captures cmd_* and starts one access the next cycle.
- Read: bus_oe=0 throughout. bus_din is sampled into rsp_data on the last STROBE clock. rsp_valid pulses for 1 clk during HOLD.
- Simultaneous start and cmd_valid in READY: start wins, command not accepted.
- cmd_valid before init_done: cmd_ready stays 0.
- The strobe counter is 4 bits. It reloads STROBE_CYCLES-1 on SETUP exit and counts down to 0. No wrap.

Decomposition:
- Shared package pic_pkg holds:
  - ICW/OCW bit-position constants
  - step enum {ICW1, ICW2, ICW3, ICW4, OCW1, DONE}
  - access-FSM enum {IDLE, LOAD, SETUP, STROBE, HOLD, READY}
- One natural sub-module, pic_bus_access: single-access strobe/timing FSM with go/done handshake. The top holds step sequencing, cfg snapshot and the command port.

Test Plan:
- sngl=1, ic4=0, vector_base=5'h08, mask=8'hFF, start, STROBE_CYCLES=2 -> three writes: (A0=0, 8'h12), (A0=1, 8'h40), (A0=1, 8'hFF). init_done rises 14 clks after start.
- sngl=0, ic4=1, ltim=1, icw3=8'h04, aeoi=1, ms=1, buf=1 -> five writes: 8'h19, base<<3, 8'h04, 8'h0F, mask. A0 sequence is 0,1,1,1,1.
- After init, command read A0=0 with bus_din=8'hA5 -> RD low 2 clks, WD stays 1, bus_oe=0, rsp_valid pulse with rsp_data=8'hA5.
- Reset asserted during ICW2 STROBE -> next edge WD=1, bus_oe=0, busy=0, init_done=0. A new start replays from ICW1.
- start pulse while busy, and cmd_valid before init_done -> both ignored; cmd_ready stays 0 and the byte sequence is unchanged.
- In READY, start and cmd_valid asserted in the same cycle -> command not accepted, init sequence restarts, init_done drops next clk.

Source files
------------

// File: rtl/pic_pkg.sv
// Shared types and byte encoders for the 8259 PIC bus sequencer.
// Step order and ICW/OCW bit layout live here so the top and bench-facing logic agree.
package pic_pkg;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_LTIM = 3;
    localparam int ICW1_ID   = 4;
    localparam int ICW4_UPM  = 0;
    localparam int ICW4_AEOI = 1;
    localparam int ICW4_MS   = 2;
    localparam int ICW4_BUF  = 3;

    typedef enum logic [2:0] {ICW1, ICW2, ICW3, ICW4, OCW1, DONE} step_t;

    typedef enum logic [2:0] {IDLE, LOAD, SETUP, STROBE, HOLD, READY} access_state_t;

    typedef struct packed {
        logic       ltim;
        logic       sngl;
        logic       ic4;
        logic [4:0] vector_base;
        logic [7:0] icw3;
        logic       aeoi;
        logic       ms;
        logic       buf_mode;
        logic [7:0] mask;
    } init_cfg_t;

    typedef struct packed {
        logic       a0;
        logic [7:0] data;
    } bus_byte_t;

    function automatic bus_byte_t init_byte(step_t s, init_cfg_t c, logic upm);
        bus_byte_t b;
        b = '0;
        case (s)
            ICW1: begin
                b.a0              = 1'b0;
                b.data[ICW1_ID]   = 1'b1;
                b.data[ICW1_LTIM] = c.ltim;
                b.data[ICW1_SNGL] = c.sngl;
                b.data[ICW1_IC4]  = c.ic4;
            end
            ICW2: b = {1'b1, c.vector_base, 3'b000};
            ICW3: b = {1'b1, c.icw3};
            ICW4: begin
                b.a0              = 1'b1;
                b.data[ICW4_BUF]  = c.buf_mode;
                b.data[ICW4_MS]   = c.ms;
                b.data[ICW4_AEOI] = c.aeoi;
                b.data[ICW4_UPM]  = upm;
            end
            OCW1: b = {1'b1, c.mask};
            default: b = '0;
        endcase
        return b;
    endfunction

    // Optional ICW3/ICW4 are skipped using the latched configuration.
    function automatic step_t next_step(step_t s, init_cfg_t c);
        step_t n;
        case (s)
            ICW1: n = ICW2;
            ICW2: n = !c.sngl ? ICW3 : (c.ic4 ? ICW4 : OCW1);
            ICW3: n = c.ic4 ? ICW4 : OCW1;
            ICW4: n = OCW1;
            default: n = DONE;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/pic_bus_access.sv
// One 8259 register access: SETUP, STROBE_CYCLES of WD/RD low, HOLD.
// Address/data are captured on go and held until the next access.
module pic_bus_access
    import pic_pkg::*;
#(
    parameter int STROBE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       go,
    input  logic       read,
    input  logic       a0,
    input  logic [7:0] data,
    output logic       done,
    output logic       wd,
    output logic       rd,
    output logic       bus_a0,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din,
    output logic       rsp_valid,
    output logic [7:0] rsp_data
);

    localparam logic [3:0] RELOAD = 4'(STROBE_CYCLES - 1);

    access_state_t state, state_n;
    logic [3:0]    cnt;
    logic          read_q;
    logic          strobe;

    // NOTE: sequential state is written only with non-blocking assignments.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            read_q   <= 1'b0;
            bus_a0   <= 1'b0;
            bus_dout <= '0;
            rsp_data <= '0;
        end else begin
            state <= state_n;
            if (state == IDLE && go) begin
                read_q   <= read;
                bus_a0   <= a0;
                bus_dout <= data;
            end
            if (state == SETUP) begin
                cnt <= RELOAD;
            end else if (state == STROBE && cnt != '0) begin
                cnt <= cnt - 4'd1;
            end
            if (state == STROBE && cnt == '0 && read_q) begin
                rsp_data <= bus_din;
            end
        end
    end

    // NOTE: next state gets a default first so no latch is inferred.
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (go) state_n = SETUP;
            SETUP:   state_n = STROBE;
            STROBE:  if (cnt == '0) state_n = HOLD;
            HOLD:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Strobes decode straight from state so WD and RD can never overlap.
    assign strobe    = (state == STROBE);
    assign wd        = !(strobe && !read_q);
    assign rd        = !(strobe && read_q);
    assign bus_oe    = !read_q && (state == SETUP || state == STROBE || state == HOLD);
    assign done      = (state == HOLD);
    assign rsp_valid = (state == HOLD) && read_q;

endmodule

// File: rtl/pic_bus_sequencer.sv
// 8259 PIC bus master: replays ICW1..OCW1 from a config snapshot on start,
// then serves single runtime register reads/writes.
module pic_bus_sequencer
    import pic_pkg::*;
#(
    parameter int   STROBE_CYCLES = 2,
    parameter logic UPM_8086      = 1'b1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       cfg_ltim,
    input  logic       cfg_sngl,
    input  logic       cfg_ic4,
    input  logic [4:0] cfg_vector_base,
    input  logic [7:0] cfg_icw3,
    input  logic       cfg_aeoi,
    input  logic       cfg_ms,
    input  logic       cfg_buf,
    input  logic [7:0] cfg_mask,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic       cmd_read,
    input  logic       cmd_a0,
    input  logic [7:0] cmd_data,
    output logic       rsp_valid,
    output logic [7:0] rsp_data,
    output logic       busy,
    output logic       init_done,
    output logic       WD,
    output logic       RD,
    output logic       A0,
    output logic [7:0] bus_dout,
    output logic       bus_oe,
    input  logic [7:0] bus_din
);

    // phase uses HOLD to mean "an access is in flight, waiting for its HOLD".
    access_state_t phase, phase_n;
    step_t         step_q, step_n;
    init_cfg_t     cfg_q, cfg_n, cfg_in;
    logic          busy_n, init_done_n;
    logic          go, go_read, acc_done;
    bus_byte_t     go_byte;

    assign cfg_in = '{ltim: cfg_ltim, sngl: cfg_sngl, ic4: cfg_ic4,
                      vector_base: cfg_vector_base, icw3: cfg_icw3,
                      aeoi: cfg_aeoi, ms: cfg_ms, buf_mode: cfg_buf, mask: cfg_mask};

    assign cmd_ready = (phase == READY) && init_done && !busy && !start;

    always_ff @(posedge clk) begin
        if (reset) begin
            phase     <= IDLE;
            step_q    <= ICW1;
            cfg_q     <= '0;
            busy      <= 1'b0;
            init_done <= 1'b0;
        end else begin
            phase     <= phase_n;
            step_q    <= step_n;
            cfg_q     <= cfg_n;
            busy      <= busy_n;
            init_done <= init_done_n;
        end
    end

    always_comb begin
        phase_n     = phase;
        step_n      = step_q;
        cfg_n       = cfg_q;
        busy_n      = busy;
        init_done_n = init_done;
        go          = 1'b0;
        go_read     = 1'b0;
        go_byte     = '0;
        case (phase)
            IDLE, READY: begin
                // start has priority; cmd_ready is already low while start is high.
                if (start) begin
                    cfg_n       = cfg_in;
                    step_n      = ICW1;
                    init_done_n = 1'b0;
                    busy_n      = 1'b1;
                    go          = 1'b1;
                    go_byte     = init_byte(ICW1, cfg_in, UPM_8086);
                    phase_n     = HOLD;
                end else if (cmd_valid && cmd_ready) begin
                    busy_n  = 1'b1;
                    go      = 1'b1;
                    go_read = cmd_read;
                    go_byte = {cmd_a0, cmd_read ? 8'h00 : cmd_data};
                    phase_n = HOLD;
                end
            end
            LOAD: begin
                go      = 1'b1;
                go_byte = init_byte(step_q, cfg_q, UPM_8086);
                phase_n = HOLD;
            end
            HOLD: begin
                if (acc_done) begin
                    if (!init_done) begin
                        step_n = next_step(step_q, cfg_q);
                        if (step_n == DONE) begin
                            phase_n     = READY;
                            busy_n      = 1'b0;
                            init_done_n = 1'b1;
                        end else begin
                            phase_n = LOAD;
                        end
                    end else begin
                        phase_n = READY;
                        busy_n  = 1'b0;
                    end
                end
            end
            default: phase_n = IDLE;
        endcase
    end

    pic_bus_access #(
        .STROBE_CYCLES(STROBE_CYCLES)
    ) u_access (
        .clk      (clk),
        .reset    (reset),
        .go       (go),
        .read     (go_read),
        .a0       (go_byte.a0),
        .data     (go_byte.data),
        .done     (acc_done),
        .wd       (WD),
        .rd       (RD),
        .bus_a0   (A0),
        .bus_dout (bus_dout),
        .bus_oe   (bus_oe),
        .bus_din  (bus_din),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data)
    );

endmodule

// File: tb/tb_pic_bus_sequencer.sv
// Bench for pic_bus_sequencer: a timeline model predicts every output each cycle,
// directed scenarios pin the model with literal byte sequences and latencies.
module tb_pic_bus_sequencer;

    localparam int S = 2;
    localparam int P = S + 3;

    logic       clk = 1'b0;
    logic       reset, start;
    logic       cfg_ltim, cfg_sngl, cfg_ic4, cfg_aeoi, cfg_ms, cfg_buf;
    logic [4:0] cfg_vector_base;
    logic [7:0] cfg_icw3, cfg_mask;
    logic       cmd_valid, cmd_ready, cmd_read, cmd_a0;
    logic [7:0] cmd_data;
    logic       rsp_valid;
    logic [7:0] rsp_data;
    logic       busy, init_done, WD, RD, A0, bus_oe;
    logic [7:0] bus_dout, bus_din;

    pic_bus_sequencer #(.STROBE_CYCLES(S), .UPM_8086(1'b1)) dut (
        .clk(clk), .reset(reset), .start(start),
        .cfg_ltim(cfg_ltim), .cfg_sngl(cfg_sngl), .cfg_ic4(cfg_ic4),
        .cfg_vector_base(cfg_vector_base), .cfg_icw3(cfg_icw3),
        .cfg_aeoi(cfg_aeoi), .cfg_ms(cfg_ms), .cfg_buf(cfg_buf), .cfg_mask(cfg_mask),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_a0(cmd_a0), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_data(rsp_data),
        .busy(busy), .init_done(init_done),
        .WD(WD), .RD(RD), .A0(A0), .bus_dout(bus_dout), .bus_oe(bus_oe),
        .bus_din(bus_din)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic din_hold = 1'b0;
    always @(posedge clk) begin
        #1;
        bus_din = din_hold ? 8'hA5 : 8'($urandom);
    end

    // Timeline model: an accepted job is a list of bytes; byte k occupies
    // P cycles starting k*P after acceptance (SETUP, S strobes, HOLD, LOAD).
    typedef struct packed {
        logic       rd;
        logic       a0;
        logic [7:0] d;
    } acc_t;

    acc_t       mq[$];
    bit         m_active, m_busy, m_init_done, m_is_init;
    bit         m_a0;
    bit [7:0]   m_dout, m_rsp;
    int         m_j;
    bit         acc_start, acc_cmd;

    always @(posedge clk) begin
        if (reset) begin
            m_active = 0; m_busy = 0; m_init_done = 0; m_is_init = 0;
            m_a0 = 0; m_dout = 0; m_rsp = 0; m_j = 0;
            mq.delete();
        end else begin
            acc_start = start && !m_busy;
            acc_cmd   = cmd_valid && m_init_done && !m_busy && !start;
            if (m_active) begin
                m_j++;
                if (mq[m_j / P].rd && (m_j % P) == S + 1) m_rsp = bus_din;
                if (m_j == mq.size() * P - 1) begin
                    m_active = 0;
                    m_busy   = 0;
                    if (m_is_init) m_init_done = 1;
                    m_a0   = mq[$].a0;
                    m_dout = mq[$].d;
                end
            end
            if (acc_start) begin
                mq.delete();
                mq.push_back({1'b0, 1'b0, 3'b000, 1'b1, cfg_ltim, 1'b0, cfg_sngl, cfg_ic4});
                mq.push_back({1'b0, 1'b1, cfg_vector_base, 3'b000});
                if (!cfg_sngl) mq.push_back({1'b0, 1'b1, cfg_icw3});
                if (cfg_ic4) mq.push_back({1'b0, 1'b1, 4'b0000, cfg_buf, cfg_ms, cfg_aeoi, 1'b1});
                mq.push_back({1'b0, 1'b1, cfg_mask});
                m_is_init = 1; m_active = 1; m_j = 0; m_busy = 1; m_init_done = 0;
            end else if (acc_cmd) begin
                mq.delete();
                mq.push_back({cmd_read, cmd_a0, cmd_data});
                m_is_init = 0; m_active = 1; m_j = 0; m_busy = 1;
            end
        end
    end

    // Per-cycle comparison against the model, sampled mid-cycle.
    bit         cmp_en = 0;
    bit         prev_wd = 1;
    logic [8:0] wlog[$];
    bit         e_wd, e_rd, e_a0, e_oe, e_rv;
    bit [7:0]   e_dout;
    int         ck, cp;
    acc_t       ce;

    always @(negedge clk) begin
        if (cmp_en) begin
            if (m_active) begin
                ck = m_j / P;
                cp = m_j % P;
                ce = mq[ck];
                e_a0   = ce.a0;
                e_dout = ce.d;
                e_oe   = !ce.rd && cp <= S + 1;
                e_wd   = !(cp >= 1 && cp <= S && !ce.rd);
                e_rd   = !(cp >= 1 && cp <= S && ce.rd);
                e_rv   = ce.rd && cp == S + 1;
            end else begin
                e_a0 = m_a0; e_dout = m_dout; e_oe = 0; e_wd = 1; e_rd = 1; e_rv = 0;
            end
            check("WD", WD, e_wd);
            check("RD", RD, e_rd);
            check("A0", A0, e_a0);
            check("bus_oe", bus_oe, e_oe);
            if (e_oe) check("bus_dout", bus_dout, e_dout);
            check("busy", busy, m_busy);
            check("init_done", init_done, m_init_done);
            check("cmd_ready", cmd_ready, m_init_done && !m_busy && !start);
            check("rsp_valid", rsp_valid, e_rv);
            check("rsp_data", rsp_data, m_rsp);
            if (prev_wd && !WD) wlog.push_back({A0, bus_dout});
            prev_wd = WD;
        end
    end

    logic [8:0] ex[$];

    task automatic check_log(input string tag);
        check({tag, " count"}, wlog.size(), ex.size());
        for (int i = 0; i < ex.size() && i < wlog.size(); i++)
            check($sformatf("%s byte%0d", tag, i), wlog[i], ex[i]);
    endtask

    task automatic set_cfg(input logic l, input logic s1, input logic i4, input logic [4:0] vb,
                           input logic [7:0] i3, input logic ae, input logic m,
                           input logic b, input logic [7:0] mk);
        cfg_ltim = l; cfg_sngl = s1; cfg_ic4 = i4; cfg_vector_base = vb; cfg_icw3 = i3;
        cfg_aeoi = ae; cfg_ms = m; cfg_buf = b; cfg_mask = mk;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        for (int i = 0; i < 200; i++) begin
            if (init_done && !busy) break;
            tick();
        end
        check({tag, " reach ready"}, init_done && !busy, 1'b1);
    endtask

    int n;
    int rd_low;

    initial begin
        reset = 1'b1; start = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_a0 = 1'b0;
        cmd_data = 8'h00; bus_din = 8'h00;
        set_cfg(0, 1, 0, 5'h08, 8'h00, 0, 0, 0, 8'hFF);
        repeat (3) tick();
        reset = 1'b0;
        cmp_en = 1;

        check("reset WD", WD, 1'b1);
        check("reset RD", RD, 1'b1);
        check("reset A0", A0, 1'b0);
        check("reset bus_dout", bus_dout, 8'h00);
        check("reset bus_oe", bus_oe, 1'b0);
        check("reset busy", busy, 1'b0);
        check("reset init_done", init_done, 1'b0);
        check("reset rsp_data", rsp_data, 8'h00);

        // Single PIC, no ICW4: three writes, init_done 14 clocks after start.
        wlog.delete();
        pulse_start();
        n = 0;
        for (int i = 1; i <= 100; i++) begin
            tick();
            if (init_done) begin n = i; break; end
        end
        check("init_done latency", n, 14);
        ex = '{9'h012, 9'h140, 9'h1FF};
        check_log("single");

        // Cascade with ICW4; a mid-sequence start and early cmd_valid are ignored.
        set_cfg(1, 0, 1, 5'h0A, 8'h04, 1, 1, 1, 8'hC3);
        wlog.delete();
        pulse_start();
        repeat (3) tick();
        start = 1'b1;
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'h77;
        for (int i = 0; i < 10; i++) begin
            #1;
            check("cmd_ready before init", cmd_ready, 1'b0);
            tick();
            start = 1'b0;
        end
        cmd_valid = 1'b0;
        wait_ready("cascade");
        ex = '{9'h019, 9'h150, 9'h104, 9'h10F, 9'h1C3};
        check_log("cascade");

        // Runtime status read.
        din_hold = 1'b1;
        tick();
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_a0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (cmd_ready) break;
            tick();
        end
        tick();
        cmd_valid = 1'b0;
        rd_low = 0;
        for (int i = 0; i < 20; i++) begin
            if (!RD) rd_low++;
            if (rsp_valid) break;
            tick();
        end
        check("read rsp_valid", rsp_valid, 1'b1);
        check("read rsp_data", rsp_data, 8'hA5);
        check("read RD low cycles", rd_low, S);
        din_hold = 1'b0;
        wait_ready("after read");

        // Reset during the ICW2 strobe, then a clean replay from ICW1.
        pulse_start();
        for (int i = 0; i < 60; i++) begin
            if (!WD && A0) break;
            tick();
        end
        check("reach ICW2 strobe", !WD && A0, 1'b1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset WD", WD, 1'b1);
        check("midreset bus_oe", bus_oe, 1'b0);
        check("midreset busy", busy, 1'b0);
        check("midreset init_done", init_done, 1'b0);
        wlog.delete();
        pulse_start();
        wait_ready("replay");
        ex = '{9'h019, 9'h150, 9'h104, 9'h10F, 9'h1C3};
        check_log("replay");

        // start and cmd_valid together in READY: start wins.
        wlog.delete();
        start = 1'b1; cmd_valid = 1'b1; cmd_read = 1'b0; cmd_a0 = 1'b1; cmd_data = 8'h3C;
        #1;
        check("collide cmd_ready", cmd_ready, 1'b0);
        tick();
        start = 1'b0; cmd_valid = 1'b0;
        check("collide init_done drop", init_done, 1'b0);
        check("collide busy", busy, 1'b1);
        wait_ready("collide");
        ex = '{9'h019, 9'h150, 9'h104, 9'h10F, 9'h1C3};
        check_log("collide");

        // Random traffic: config churns every cycle, so only the snapshot may matter.
        for (int i = 0; i < 3000; i++) begin
            reset     = ($urandom_range(0, 399) == 0);
            start     = ($urandom_range(0, 49) == 0);
            cmd_valid = ($urandom_range(0, 2) == 0);
            cmd_read  = 1'($urandom);
            cmd_a0    = 1'($urandom);
            cmd_data  = 8'($urandom);
            set_cfg(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom), 8'($urandom),
                    1'($urandom), 1'($urandom), 1'($urandom), 8'($urandom));
            tick();
        end
        reset = 1'b0; start = 1'b0; cmd_valid = 1'b0;
        repeat (60) tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
